// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants shared by the RV32I core datapath blocks.
//   XLEN       - integer register width
//   REG_NUM    - number of architectural integer registers
//   REG_ADDR_W - width of a register index
//   REG_ZERO   - index of the hard-wired zero register x0
//   REG_SP     - index of the stack pointer x2
//   SP_RESET   - value loaded into sp while reset is asserted
package rv32i_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

  localparam logic [XLEN-1:0] SP_RESET = 32'h0000_7FFC;

  // Reset contents of one register: sp gets the initial stack top, everything else clears.
  function automatic logic [XLEN-1:0] regResetValue(input int unsigned idx);
    regResetValue = (idx == int'(REG_SP)) ? SP_RESET : '0;
  endfunction

endpackage

// File: rtl/regfile_decoder_5to32.sv
// decoder_5to32: binary-to-one-hot decoder used for register write enables.
//   addr_i   in  5   binary index
//   onehot_o out 32  bit addr_i set, all other bits clear
module decoder_5to32
  import rv32i_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr_i,
  output logic [REG_NUM-1:0]    onehot_o
);

  // Exactly one output bit is high for every input value.
  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/regfile.sv
// regfile: RV32I architectural integer register file.
//   clk_i       in  1     core clock, writes commit on rising edge
//   rst_ni      in  1     asynchronous active-low reset
//   rs1_addr_i  in  5     read port 1 index
//   rs2_addr_i  in  5     read port 2 index
//   rd_addr_i   in  5     write port index
//   rd_wren_i   in  1     write request
//   rd_data_i   in  XLEN  write-back data
//   rs1_data_o  out XLEN  x[rs1_addr_i], combinational
//   rs2_data_o  out XLEN  x[rs2_addr_i], combinational
// x0 has no storage and always reads zero. There is no write-to-read bypass:
// a read of the register being written returns the old value until the edge.
module regfile
  import rv32i_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_wren_i,
  input  logic [XLEN-1:0]       rd_data_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o
);

  logic [REG_NUM-1:0] rdOnehot;
  logic [REG_NUM-1:1] wrEn;
  logic               unusedX0Sel;

  logic [XLEN-1:0] xReg_q  [1:REG_NUM-1];
  logic [XLEN-1:0] xReg_d  [1:REG_NUM-1];
  logic [XLEN-1:0] regView [0:REG_NUM-1];

  decoder_5to32 u_rdDecoder (
    .addr_i   (rd_addr_i),
    .onehot_o (rdOnehot)
  );

  // x0 has no flop, so its decoder line goes nowhere; that is how x0 writes get dropped.
  assign unusedX0Sel = rdOnehot[0];
  assign wrEn        = {(REG_NUM-1){rd_wren_i}} & rdOnehot[REG_NUM-1:1];

  always_comb begin
    for (int k = 1; k < REG_NUM; k++) begin
      xReg_d[k] = wrEn[k] ? rd_data_i : xReg_q[k];
    end
  end

  // Reset is asynchronous so the register state (and the read ports) reach reset
  // contents without a clock; a write pending when reset falls is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 1; k < REG_NUM; k++) begin
        xReg_q[k] <= regResetValue(k);
      end
    end else begin
      for (int k = 1; k < REG_NUM; k++) begin
        xReg_q[k] <= xReg_d[k];
      end
    end
  end

  // Full 32-entry view with x0 tied to zero, so both read muxes are plain indexed selects.
  always_comb begin
    regView[0] = '0;
    for (int k = 1; k < REG_NUM; k++) begin
      regView[k] = xReg_q[k];
    end
  end

  assign rs1_data_o = regView[rs1_addr_i];
  assign rs2_data_o = regView[rs2_addr_i];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile. A reference model of
// the 32 registers is updated alongside each write; each read pushes the model
// values for both ports into a scoreboard queue, which is popped and compared
// once the combinational outputs have settled.
module tb_regfile;
  import rv32i_pkg::*;

  logic                  clk;
  logic                  rstN;
  logic [REG_ADDR_W-1:0] rs1Addr;
  logic [REG_ADDR_W-1:0] rs2Addr;
  logic [REG_ADDR_W-1:0] rdAddr;
  logic                  rdWren;
  logic [XLEN-1:0]       rdData;
  logic [XLEN-1:0]       rs1Data;
  logic [XLEN-1:0]       rs2Data;

  logic [XLEN-1:0] model [0:REG_NUM-1];
  logic [XLEN-1:0] expQ  [$];

  int checks = 0;
  int errors = 0;

  regfile dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .rs1_addr_i (rs1Addr),
    .rs2_addr_i (rs2Addr),
    .rd_addr_i  (rdAddr),
    .rd_wren_i  (rdWren),
    .rd_data_i  (rdData),
    .rs1_data_o (rs1Data),
    .rs2_data_o (rs2Data)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference reset contents.
  task automatic resetModel();
    for (int k = 0; k < REG_NUM; k++) model[k] = '0;
    model[2] = 32'h0000_7FFC;
  endtask

  // Drive one write on the next falling edge and let it commit on the following rising edge.
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    rdAddr = a;
    rdData = d;
    rdWren = en;
    @(posedge clk);
    if (rstN && en && a != 5'd0) model[a] = d;
    #1;
    rdWren = 1'b0;
  endtask

  // Present both read addresses, queue the model's answers, then compare after settling.
  task automatic checkOutput(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    logic [31:0] exp1;
    logic [31:0] exp2;
    rs1Addr = a1;
    rs2Addr = a2;
    expQ.push_back(model[a1]);
    expQ.push_back(model[a2]);
    #1;
    exp1 = expQ.pop_front();
    exp2 = expQ.pop_front();
    checks++;
    assert (rs1Data === exp1) else begin
      errors++;
      $error("[TB] FAIL %s rs1[x%0d]: observed %h expected %h", tag, a1, rs1Data, exp1);
    end
    checks++;
    assert (rs2Data === exp2) else begin
      errors++;
      $error("[TB] FAIL %s rs2[x%0d]: observed %h expected %h", tag, a2, rs2Data, exp2);
    end
  endtask

  initial begin
    rstN    = 1'b1;
    rs1Addr = '0;
    rs2Addr = '0;
    rdAddr  = '0;
    rdWren  = 1'b0;
    rdData  = '0;

    // Asynchronous reset mid-cycle: contents must appear before the edge at 5 ns.
    #3;
    rstN = 1'b0;
    resetModel();
    checkOutput(5'd2, 5'd0, "reset_async");
    for (int k = 0; k < REG_NUM; k++) begin
      @(negedge clk);
      checkOutput(5'(k), 5'(REG_NUM - 1 - k), "reset_all");
    end
    @(negedge clk);
    rstN = 1'b1;
    $display("[TB] reset released at %0t", $time);

    // Write/readback sweep over x1..x31, then read back on both ports.
    for (int k = 1; k < REG_NUM; k++) begin
      applyStimulus(5'(k), 32'hA5A5_0000 | 32'(k), 1'b1);
    end
    for (int k = 0; k < REG_NUM; k++) begin
      @(negedge clk);
      checkOutput(5'(k), 5'((k + 13) % REG_NUM), "sweep");
    end

    // Writes to x0 are dropped.
    applyStimulus(5'd0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    checkOutput(5'd0, 5'd0, "x0_protect");

    // No write when rd_wren_i is low.
    applyStimulus(5'd5, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checkOutput(5'd5, 5'd5, "wren_low");

    // Same-cycle read of rd returns the old value until the edge.
    applyStimulus(5'd7, 32'h0000_0001, 1'b1);
    @(negedge clk);
    rdAddr = 5'd7;
    rdData = 32'h0000_0002;
    rdWren = 1'b1;
    checkOutput(5'd7, 5'd6, "rd_before_edge");
    @(posedge clk);
    model[7] = 32'h0000_0002;
    #1;
    rdWren = 1'b0;
    checkOutput(5'd7, 5'd8, "rd_after_edge");

    // Reset falling while a write to x9 is pending: the write is lost.
    @(negedge clk);
    rdAddr = 5'd9;
    rdData = 32'hFFFF_FFFF;
    rdWren = 1'b1;
    #2;
    rstN = 1'b0;
    resetModel();
    checkOutput(5'd9, 5'd2, "reset_during_write");
    @(posedge clk);
    #1;
    checkOutput(5'd9, 5'd7, "reset_hold");
    rdWren = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput(5'd9, 5'd2, "post_reset");
    applyStimulus(5'd9, 32'h0BAD_F00D, 1'b1);
    @(negedge clk);
    checkOutput(5'd9, 5'd10, "first_write_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file of the single-cycle RV32I core: 32 × 32-bit registers, two combinational read ports (rs1, rs2) and one synchronous write port (rd). It sits between instruction decode and the ALU: decode supplies register indices, write-back supplies rd data, and the ALU/branch unit consumes rs1/rs2 data. Write-enable fan-out is one-hot, produced by the team's 5-to-32 decoder.

## Interface
- XLEN, 32, data width of each register
- SP_RESET, 32'h0000_7FFC, reset value of x2 (sp); all other registers reset to 0
- clk_i  in  1  core clock, all writes on rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- rs1_addr_i  in  5  read port 1 index (instr[19:15])
- rs2_addr_i  in  5  read port 2 index (instr[24:20])
- rd_addr_i  in  5  write port index (instr[11:7])
- rd_wren_i  in  1  write request from control unit
- rd_data_i  in  XLEN  write-back data
- rs1_data_o  out  XLEN  contents of x[rs1_addr_i]
- rs2_data_o  out  XLEN  contents of x[rs2_addr_i]

## Operation
- Storage: registers x1..x31 are flops; x0 is not stored and reads as 32'h0 always.
- Write decode: rd_addr_i drives decoder_5to32; per-register enable = rd_wren_i & onehot[k]; bit 0 of the one-hot is discarded.
- Write: on rising clk_i with rst_ni high, rd_wren_i=1 and rd_addr_i≠0 → x[rd_addr_i] ← rd_data_i. Exactly one register changes; all others hold.
- Write to x0 (rd_addr_i=0, rd_wren_i=1): silently dropped, no state change.
- rd_wren_i=0: no register changes regardless of rd_addr_i / rd_data_i.
- Read: rs1_data_o / rs2_data_o are pure combinational muxes of current register state; both ports independent, may address the same register.
- No internal write-to-read bypass: single-cycle core reads and writes the same instruction's operands at different phases; a read of rd returns the old value until the write edge.
- Reset: rst_ni low → immediately (no clock needed) x2 = SP_RESET, every other stored register = 0. Held while rst_ni low; writes ignored during reset.

## Timing
- Write latency: 1 clock; new value visible on read ports after the rising edge that commits it (combinational settle only).
- Read latency: 0 clocks (combinational from rsN_addr_i and register state).
- Reset assertion: asynchronous, outputs reflect reset contents within combinational delay of rst_ni falling.
- Reset deassertion: first write accepted on the first rising edge with rst_ni high; reset deassertion is assumed synchronised upstream.
- Reset mid-operation: rst_ni falling in the same cycle as a pending write → write lost, register holds reset value.
- Output values after reset: rsN_data_o = 0 except when rsN_addr_i=2 → SP_RESET.

## Structure
- Shared package rv32i_pkg: XLEN=32, REG_NUM=32, REG_ADDR_W=5, REG_ZERO=5'd0, REG_SP=5'd2, SP_RESET default.
- One sub-module instance: decoder_5to32 for rd write-enable generation.
- Register array: 31 XLEN-bit flops with async active-low clear/preset per register; read muxes as two 32:1 case/indexed selects with x0 forced to 0.

## Test plan
- Reset: pulse rst_ni low mid-cycle → all 32 addresses read 0 except x2 = 32'h0000_7FFC, without any clock edge.
- Write/readback sweep: for k=1..31 write 32'hA5A5_0000|k, then read each on rs1 and rs2 → exact values; no aliasing between indices.
- x0 protection: write 32'hDEAD_BEEF to rd=0 with rd_wren_i=1 → rs1_data_o and rs2_data_o for addr 0 remain 32'h0.
- Write disable: rd_wren_i=0, rd=5, data 32'h1234_5678 → x5 unchanged on following cycle.
- Same-cycle read of rd: x7=32'h1, write 32'h2 to x7 while rs1_addr_i=7 → rs1_data_o=32'h1 before edge, 32'h2 after edge.
- Reset during write: rst_ni falls with write 32'hFFFF_FFFF to x9 pending → x9 reads 0 after reset; first post-reset write to x9 succeeds.
